// File: rtl/paddle_pkg.sv
// Shared types and screen constants for the Breakout paddle.
package paddle_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE_L = 2'd1,
    MOVE_R = 2'd2
  } paddle_state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_L    = 2'd1,
    DIR_R    = 2'd2
  } paddle_dir_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Left edge offset of hit segment i for a paddle of width w split into n parts.
  function automatic int seg_bound(input int w, input int n, input int i);
    return (i * w) / n;
  endfunction

endpackage

// File: rtl/paddle_segment.sv
// Maps the ball centre onto one of NUM_SEG horizontal paddle segments.
// Segment boundaries are constants for both the full and the halved width.
module paddle_segment
  import paddle_pkg::*;
#(
  parameter int WIDTH   = 70,
  parameter int NUM_SEG = 5,
  localparam int SEG_W  = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
) (
  input  logic              [9:0]  ball_x,
  input  logic signed       [11:0] paddle_x,
  input  logic                     shrunk,
  output logic          [SEG_W-1:0] seg
);

  localparam int FULL_W = WIDTH;
  localparam int HALF_W = WIDTH / 2;

  logic signed [12:0] ball_s;
  logic signed [12:0] px_s;
  logic signed [12:0] off;
  logic signed [12:0] w_s;

  assign ball_s = signed'({3'b000, ball_x});
  assign px_s   = signed'({paddle_x[11], paddle_x});
  assign off    = ball_s - px_s;
  assign w_s    = shrunk ? 13'(HALF_W) : 13'(FULL_W);

  // Pick the highest segment whose left boundary the ball has passed.
  always_comb begin
    seg = '0;
    if (off < 0) begin
      seg = '0;
    end else if (off >= w_s) begin
      seg = SEG_W'(NUM_SEG - 1);
    end else begin
      for (int i = 1; i < NUM_SEG; i++) begin
        if (shrunk) begin
          if (off >= 13'(seg_bound(HALF_W, NUM_SEG, i))) seg = SEG_W'(i);
        end else begin
          if (off >= 13'(seg_bound(FULL_W, NUM_SEG, i))) seg = SEG_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// Breakout paddle: accelerating movement, exact edge clamping, one-shot
// shrink to half width, pixel hit test and ball segment lookup.
//
// state  | meaning
// IDLE   | no direction held, speed 0
// MOVE_L | moving left, accelerating while held
// MOVE_R | moving right, accelerating while held
module paddle_ctrl
  import paddle_pkg::*;
#(
  parameter int X_POS       = 285,
  parameter int Y_POS       = 449,
  parameter int WIDTH       = 70,
  parameter int HEIGHT      = 12,
  parameter int SPEED_MIN   = 1,
  parameter int SPEED_MAX   = 4,
  parameter int ACCEL_TICKS = 8,
  parameter int NUM_SEG     = 5,
  localparam int SEG_W      = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    refresh_tick,
  input  logic              [9:0] pixel_x,
  input  logic              [9:0] pixel_y,
  input  logic                    left,
  input  logic                    right,
  input  logic                    shrink,
  input  logic              [9:0] ball_x,
  output logic                    paddle_on,
  output logic signed      [11:0] paddle_x,
  output logic              [9:0] paddle_w,
  output logic        [SEG_W-1:0] paddle_seg,
  output logic              [2:0] speed
);

  localparam int CNT_W = $clog2(ACCEL_TICKS + 1);
  localparam logic signed [11:0] SCR_W_S  = 12'(SCREEN_W);
  localparam logic signed [11:0] QUARTER  = 12'(WIDTH / 4);
  localparam logic        [9:0]  FULL_W   = 10'(WIDTH);
  localparam logic        [9:0]  HALF_W   = 10'(WIDTH / 2);
  localparam logic        [2:0]  SPD_MIN  = 3'(SPEED_MIN);
  localparam logic        [2:0]  SPD_MAX  = 3'(SPEED_MAX);
  localparam logic    [CNT_W-1:0] CNT_TOP = CNT_W'(ACCEL_TICKS);
  localparam logic        [9:0]  Y_TOP    = 10'(Y_POS);
  localparam logic        [9:0]  Y_BOT    = 10'(Y_POS + HEIGHT);

  paddle_state_t      state_q, state_d;
  logic signed [11:0] x_q, x_d;
  logic        [9:0]  w_q, w_d;
  logic        [2:0]  speed_q, speed_d;
  logic   [CNT_W-1:0] cnt_q, cnt_d;
  logic               pending_q, pending_d;
  logic               shrunk_q, shrunk_d;

  paddle_dir_t        dir;
  logic signed [11:0] spd_s;
  logic signed [11:0] lim;
  logic   [CNT_W-1:0] cnt_inc;
  logic signed [11:0] pix_s;
  logic signed [11:0] right_edge;

  // Register all paddle state; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      x_q       <= 12'(X_POS);
      w_q       <= FULL_W;
      speed_q   <= 3'd0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      shrunk_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      w_q       <= w_d;
      speed_q   <= speed_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      shrunk_q  <= shrunk_d;
    end
  end

  // Direction decode, FSM transitions, acceleration, shrink and clamped move.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    w_d       = w_q;
    speed_d   = speed_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    shrunk_d  = shrunk_q;
    cnt_inc   = cnt_q + CNT_W'(1);

    if (left && !right)      dir = DIR_L;
    else if (right && !left) dir = DIR_R;
    else                     dir = DIR_NONE;

    if (shrink && !shrunk_q) pending_d = 1'b1;

    if (refresh_tick) begin
      if (pending_q) begin
        // Shrink tick: recentre on the halved width, freeze motion state.
        w_d       = HALF_W;
        x_d       = x_q + QUARTER;
        shrunk_d  = 1'b1;
        pending_d = 1'b0;
      end else if (dir == DIR_NONE) begin
        state_d = IDLE;
        speed_d = 3'd0;
        cnt_d   = '0;
      end else begin
        if ((dir == DIR_L && state_q == MOVE_L) || (dir == DIR_R && state_q == MOVE_R)) begin
          if (cnt_inc >= CNT_TOP) begin
            cnt_d   = '0;
            speed_d = (speed_q < SPD_MAX) ? speed_q + 3'd1 : SPD_MAX;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          state_d = (dir == DIR_L) ? MOVE_L : MOVE_R;
          speed_d = SPD_MIN;
          cnt_d   = '0;
        end
      end
    end

    spd_s = signed'({9'b0, speed_d});
    lim   = SCR_W_S - signed'({2'b00, w_q});

    if (refresh_tick && !pending_q) begin
      if (dir == DIR_L) begin
        x_d = (x_q <= spd_s) ? 12'sd0 : x_q - spd_s;
      end else if (dir == DIR_R) begin
        x_d = (x_q + spd_s >= lim) ? lim : x_q + spd_s;
      end
    end
  end

  // Pixel hit test against the current paddle rectangle.
  always_comb begin
    pix_s      = signed'({2'b00, pixel_x});
    right_edge = x_q + signed'({2'b00, w_q});
    paddle_on  = (pix_s >= x_q) && (pix_s < right_edge) &&
                 (pixel_y >= Y_TOP) && (pixel_y < Y_BOT);
  end

  paddle_segment #(
    .WIDTH   (WIDTH),
    .NUM_SEG (NUM_SEG)
  ) u_segment (
    .ball_x   (ball_x),
    .paddle_x (x_q),
    .shrunk   (shrunk_q),
    .seg      (paddle_seg)
  );

  assign paddle_x = x_q;
  assign paddle_w = w_q;
  assign speed    = speed_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: directed scenarios plus randomized traffic, all
// outputs compared every cycle against a behavioural model.
module tb_paddle_ctrl;

  localparam int X_POS = 285, Y_POS = 449, WIDTH = 70, HEIGHT = 12;
  localparam int SPEED_MIN = 1, SPEED_MAX = 4, ACCEL_TICKS = 8, NUM_SEG = 5;

  logic clk = 1'b0;
  logic reset, refresh_tick, left, right, shrink;
  logic [9:0] pixel_x, pixel_y, ball_x;
  logic paddle_on;
  logic signed [11:0] paddle_x;
  logic [9:0] paddle_w;
  logic [2:0] paddle_seg;
  logic [2:0] speed;

  int n_pass = 0;
  int n_chk  = 0;

  int m_x, m_w, m_speed, m_cnt, m_dir;
  bit m_pend, m_shrunk;

  paddle_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .refresh_tick (refresh_tick),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .left         (left),
    .right        (right),
    .shrink       (shrink),
    .ball_x       (ball_x),
    .paddle_on    (paddle_on),
    .paddle_x     (paddle_x),
    .paddle_w     (paddle_w),
    .paddle_seg   (paddle_seg),
    .speed        (speed)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  function automatic void model_reset();
    m_x = X_POS; m_w = WIDTH; m_speed = 0; m_cnt = 0; m_dir = 0;
    m_pend = 0; m_shrunk = 0;
  endfunction

  // One clock of the paddle rules, applied to the inputs seen this cycle.
  function automatic void model_step(input bit tk, input bit l, input bit r, input bit shr);
    bit pend_now;
    int d;
    pend_now = m_pend;
    if (shr && !m_shrunk) m_pend = 1;
    if (!tk) return;
    if (pend_now) begin
      m_w = WIDTH / 2; m_x = m_x + WIDTH / 4; m_shrunk = 1; m_pend = 0;
      return;
    end
    d = (l && !r) ? -1 : ((r && !l) ? 1 : 0);
    if (d == 0) begin
      m_dir = 0; m_speed = 0; m_cnt = 0;
      return;
    end
    if (d != m_dir) begin
      m_dir = d; m_speed = SPEED_MIN; m_cnt = 0;
    end else begin
      m_cnt++;
      if (m_cnt == ACCEL_TICKS) begin
        m_cnt = 0;
        if (m_speed < SPEED_MAX) m_speed++;
      end
    end
    if (d < 0) m_x = (m_x - m_speed < 0) ? 0 : m_x - m_speed;
    else       m_x = (m_x + m_speed > 640 - m_w) ? 640 - m_w : m_x + m_speed;
  endfunction

  function automatic int model_seg(input int bx);
    int off, s;
    if (bx < m_x) return 0;
    if (bx >= m_x + m_w) return NUM_SEG - 1;
    off = bx - m_x;
    s = 0;
    for (int i = 0; i < NUM_SEG; i++) if (off >= (i * m_w) / NUM_SEG) s = i;
    return s;
  endfunction

  function automatic int model_on(input int px, input int py);
    return (px >= m_x && px < m_x + m_w && py >= Y_POS && py < Y_POS + HEIGHT) ? 1 : 0;
  endfunction

  task automatic check_all();
    chk("x",     int'(paddle_x), m_x);
    chk("w",     int'(paddle_w), m_w);
    chk("speed", int'(speed), m_speed);
    chk("seg",   int'(paddle_seg), model_seg(int'(ball_x)));
    chk("on",    int'(paddle_on), model_on(int'(pixel_x), int'(pixel_y)));
  endtask

  task automatic cyc(input bit tk, input bit l, input bit r, input bit shr, input bit rst);
    refresh_tick = tk; left = l; right = r; shrink = shr; reset = rst;
    if (rst) model_reset();
    else     model_step(tk, l, r, shr);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    bit l, r;
    int bx, px;
    reset = 1; refresh_tick = 0; left = 0; right = 0; shrink = 0;
    pixel_x = 0; pixel_y = 0; ball_x = 0;
    model_reset();

    cyc(0, 0, 0, 0, 1);
    chk("rst_x", int'(paddle_x), 285);
    chk("rst_w", int'(paddle_w), 70);
    chk("rst_speed", int'(speed), 0);

    // Segment lookup and pixel hit test at the reset position.
    ball_x = 10'd284; cyc(0, 0, 0, 0, 0); chk("seg_284", int'(paddle_seg), 0);
    ball_x = 10'd285; cyc(0, 0, 0, 0, 0); chk("seg_285", int'(paddle_seg), 0);
    ball_x = 10'd299; cyc(0, 0, 0, 0, 0); chk("seg_299", int'(paddle_seg), 1);
    ball_x = 10'd320; cyc(0, 0, 0, 0, 0); chk("seg_320", int'(paddle_seg), 2);
    ball_x = 10'd354; cyc(0, 0, 0, 0, 0); chk("seg_354", int'(paddle_seg), 4);
    ball_x = 10'd400; cyc(0, 0, 0, 0, 0); chk("seg_400", int'(paddle_seg), 4);
    pixel_x = 10'd285; pixel_y = 10'd449; cyc(0, 0, 0, 0, 0); chk("on_285_449", int'(paddle_on), 1);
    pixel_x = 10'd354; pixel_y = 10'd460; cyc(0, 0, 0, 0, 0); chk("on_354_460", int'(paddle_on), 1);
    pixel_x = 10'd355; pixel_y = 10'd449; cyc(0, 0, 0, 0, 0); chk("on_355_449", int'(paddle_on), 0);
    pixel_x = 10'd300; pixel_y = 10'd461; cyc(0, 0, 0, 0, 0); chk("on_300_461", int'(paddle_on), 0);

    // Acceleration while holding left.
    for (int k = 1; k <= 16; k++) begin
      cyc(1, 1, 0, 0, 0);
      if (k == 1) chk("acc_x1", int'(paddle_x), 284);
      if (k == 8) chk("acc_x8", int'(paddle_x), 277);
      if (k == 9) chk("acc_x9", int'(paddle_x), 275);
    end
    chk("acc_x16", int'(paddle_x), 261);
    chk("acc_speed16", int'(speed), 2);

    // Left and right edge clamps.
    for (int k = 0; k < 100; k++) cyc(1, 1, 0, 0, 0);
    chk("clamp_left", int'(paddle_x), 0);
    for (int k = 0; k < 250; k++) cyc(1, 0, 1, 0, 0);
    chk("clamp_right", int'(paddle_x), 570);

    // Both directions held stops the paddle; release restarts at minimum speed.
    cyc(0, 0, 0, 0, 1);
    for (int k = 0; k < 17; k++) cyc(1, 0, 1, 0, 0);
    chk("both_pre_speed", int'(speed), 3);
    chk("both_pre_x", int'(paddle_x), 312);
    cyc(1, 1, 1, 0, 0);
    chk("both_speed", int'(speed), 0);
    chk("both_x", int'(paddle_x), 312);
    cyc(1, 0, 1, 0, 0);
    chk("rel_speed", int'(speed), 1);
    chk("rel_x", int'(paddle_x), 313);

    // Shrink between ticks, second shrink ignored, new right limit.
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 1, 0, 0);
    chk("shr_w", int'(paddle_w), 35);
    chk("shr_x", int'(paddle_x), 302);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    chk("shr2_w", int'(paddle_w), 35);
    chk("shr2_x", int'(paddle_x), 302);
    for (int k = 0; k < 200; k++) cyc(1, 0, 1, 0, 0);
    chk("shr_lim", int'(paddle_x), 605);

    // Reset mid-move after a shrink, then shrink re-arms.
    for (int k = 0; k < 30; k++) cyc(1, 1, 0, 0, 0);
    chk("pre_rst_speed", int'(speed), 4);
    cyc(1, 1, 0, 0, 1);
    chk("mid_rst_x", int'(paddle_x), 285);
    chk("mid_rst_w", int'(paddle_w), 70);
    chk("mid_rst_speed", int'(speed), 0);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rearm_w", int'(paddle_w), 35);

    // Randomized traffic.
    l = 0; r = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        l = 1'($urandom_range(0, 1));
        r = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 1) == 0) begin
        bx = m_x - 2 + int'($urandom_range(0, 39));
        px = m_x - 2 + int'($urandom_range(0, 39));
      end else begin
        bx = int'($urandom_range(0, 639));
        px = int'($urandom_range(0, 639));
      end
      if (bx < 0) bx = 0;
      if (px < 0) px = 0;
      ball_x  = 10'(bx);
      pixel_x = 10'(px);
      pixel_y = 10'(445 + $urandom_range(0, 20));
      cyc(($urandom_range(0, 2) == 0), l, r, ($urandom_range(0, 149) == 0),
          ($urandom_range(0, 399) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
